// File: rtl/vec_mem_pkg.sv
// Shared types for the vector memory paths: the store serializer (mem_input_manager)
// and the load-gather path (mem_output_manager) use the same vector type.
package vec_mem_pkg;
    localparam int LANES  = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = $clog2(LANES);

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} store_state_t;
endpackage

// File: rtl/mem_input_manager.sv
// Vector store serializer: latches a vector + base address on start, then writes
// one lane per accepted memory cycle to consecutive word addresses.
module mem_input_manager
    import vec_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        RS_in,
    input  vec_t              input_data,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [4:0]        RS_out,
    output logic              busy,
    output logic              done
);
    store_state_t      state, state_d;
    vec_t              vbuf;
    logic [IDX_W-1:0]  idx, idx_d, idx_inc;
    logic              mem_we_d, busy_d, done_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [4:0]        rs_d;
    logic              accept, last;

    assign accept  = mem_we && mem_ready;
    assign last    = (idx == IDX_W'(LANES - 1));
    assign idx_inc = idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vbuf      <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            RS_out    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            RS_out    <= rs_d;
            busy      <= busy_d;
            done      <= done_d;
            // The buffer is only ever loaded from IDLE, so late starts cannot clobber it.
            if (state == IDLE && start)
                vbuf <= input_data;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = WRITE;
            WRITE:   if (accept && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless a transition fires.
    always_comb begin
        idx_d       = idx;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rs_d        = RS_out;
        busy_d      = busy;
        done_d      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    idx_d       = '0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_addr;
                    mem_wdata_d = input_data[0];
                    rs_d        = RS_in;
                    busy_d      = 1'b1;
                end
            end
            WRITE: begin
                if (accept) begin
                    if (last) begin
                        mem_we_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d       = idx_inc;
                        mem_addr_d  = mem_addr + 1'b1;
                        mem_wdata_d = vbuf[idx_inc];
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_input_manager.sv
// Scoreboard bench for mem_input_manager: a cycle-level model queues the expected
// writes when a store is accepted; a negedge monitor checks every presented output.
module tb_mem_input_manager;
    import vec_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst, start, mem_ready;
    logic [ADDR_W-1:0] base_addr;
    logic [4:0]        RS_in;
    vec_t              input_data;
    logic              mem_we, busy, done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [4:0]        RS_out;

    mem_input_manager dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .RS_in(RS_in),
        .input_data(input_data), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .RS_out(RS_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = idle, 1 = writing (m_cnt lanes accepted), 2 = done cycle.
    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
    wr_t        exp_q[$];
    int         m_phase = 0;
    int         m_cnt   = 0;
    logic [4:0] m_rs    = '0;
    bit         mon_en  = 0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_phase = 0;
            m_cnt   = 0;
            m_rs    = '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    for (int i = 0; i < LANES; i++)
                        exp_q.push_back('{a: base_addr + ADDR_W'(i), d: input_data[i]});
                    m_rs    = RS_in;
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: if (mem_ready) begin
                    m_cnt++;
                    if (m_cnt == LANES) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mem_we", 32'(mem_we), 32'(m_phase == 1));
            chk("busy", 32'(busy), 32'(m_phase == 1));
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("RS_out", 32'(RS_out), 32'(m_rs));
            if (mem_we && m_phase == 1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(mem_addr), 32'hDEAD);
                end else begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].a));
                    chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].d));
                    if (mem_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    int stall_lane = -1;
    int stall_left = 0;
    bit rnd_ready  = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (m_phase == 1 && m_cnt == stall_lane && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < LANES; i++) v[i] = DATA_W'($urandom);
        return v;
    endfunction

    // Issue a store; optionally pulse start / scramble data while writing, or
    // assert reset after `rst_after` accepted writes.
    task automatic do_store(input logic [ADDR_W-1:0] b, input logic [4:0] rs,
                            input vec_t v, input bit noisy, input int rst_after);
        int n;
        base_addr  = b;
        RS_in      = rs;
        input_data = v;
        start      = 1'b1;
        step();
        start      = 1'b0;
        input_data = rand_vec();
        n = 0;
        while (m_phase != 0 && n < 300) begin
            if (rst_after >= 0 && m_phase == 1 && m_cnt == rst_after) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("rst_mem_addr", 32'(mem_addr), 32'h0);
                chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
                break;
            end
            if (noisy && m_phase == 1) begin
                start      = 1'($urandom_range(0, 1));
                base_addr  = ADDR_W'($urandom);
                RS_in      = 5'($urandom);
                input_data = rand_vec();
            end
            step();
            n++;
        end
        start = 1'b0;
        if (m_phase != 0) chk("store_timeout", 32'(m_phase), 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
        base_addr = '0; RS_in = '0; input_data = '0;
        step();
        chk("reset_mem_we", 32'(mem_we), 32'h0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("reset_RS_out", 32'(RS_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        mon_en = 1;
        repeat (5) step();

        for (int i = 0; i < LANES; i++) v[i] = DATA_W'(16'h0001 + i);
        do_store(16'h0040, 5'b00010, v, 0, -1);
        repeat (2) step();

        stall_lane = 5; stall_left = 3;
        do_store(16'h0040, 5'b00010, v, 0, -1);
        stall_lane = -1;
        step();

        do_store(16'hFFFE, 5'd7, rand_vec(), 0, -1);
        do_store(16'hFFFF, 5'd9, rand_vec(), 1, -1);
        do_store(16'h1234, 5'd3, rand_vec(), 0, 7);
        step();
        do_store(16'h0100, 5'd4, v, 0, -1);

        // Reset and start at the same edge: reset must win.
        base_addr = 16'h0200; RS_in = 5'd5; input_data = v; start = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        step();

        rnd_ready = 1;
        for (int k = 0; k < 30; k++) begin
            int ra;
            ra = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LANES - 1)) : -1;
            do_store(ADDR_W'($urandom), 5'($urandom), rand_vec(), bit'($urandom_range(0, 1)), ra);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
